// File: rtl/sm83_irq_pkg.sv
// rtl/sm83_irq_pkg.sv - shared constants for the SM83 interrupt controller
package sm83_irq_pkg;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam logic [15:0] IF_ADDR_DEF = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_DEF = 16'hFFFF;

endpackage

// File: rtl/sm83_sync_edge.sv
// rtl/sm83_sync_edge.sv - N-stage synchronizer followed by a rising-edge pulse
module sm83_sync_edge #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] s;
    logic [W-1:0] s_q;

    generate
        if (N == 0) begin : g_direct
            assign s = d;
        end else begin : g_sync
            logic [W-1:0] chain [N];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < N; i++) chain[i] <= '0;
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < N; i++) chain[i] <= chain[i-1];
                end
            end

            assign s = chain[N-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= '0;
        else        s_q <= s;
    end

    assign rise = s & ~s_q;

endmodule

// File: rtl/sm83_irq_ctrl.sv
// rtl/sm83_irq_ctrl.sv - IF/IE registers, request edge capture, trigger and wake outputs
module sm83_irq_ctrl
    import sm83_irq_pkg::*;
#(
    parameter logic [15:0] IF_ADDR     = IF_ADDR_DEF,
    parameter logic [15:0] IE_ADDR     = IE_ADDR_DEF,
    parameter int          NUM_IRQ     = 5,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic        RD,
    input  logic        WR,
    input  logic [3:0]  INT_REQ,
    input  logic        JOYP_REQ_ASYNC,
    output logic [7:0]  CPU_IRQ_TRIG,
    input  logic [7:0]  CPU_IRQ_ACK,
    output logic        WAKE
);

    logic [3:0]         int_rise;
    logic               joy_rise;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] if_next;
    logic [7:0]         ie_q;
    logic [7:0]         ie_next;
    logic [NUM_IRQ-1:0] pending;
    logic               wr_q;
    logic               wr_commit;
    logic               hit_if;
    logic               hit_ie;
    logic               unused_ack;

    sm83_sync_edge #(.N(0), .W(4)) u_int_edge (
        .clk   (CLK),
        .rst_n (nRESET),
        .d     (INT_REQ),
        .rise  (int_rise)
    );

    sm83_sync_edge #(.N(SYNC_STAGES), .W(1)) u_joy_edge (
        .clk   (CLK),
        .rst_n (nRESET),
        .d     (JOYP_REQ_ASYNC),
        .rise  (joy_rise)
    );

    assign unused_ack = &{1'b0, CPU_IRQ_ACK[7:NUM_IRQ]};
    assign hit_if     = (A == IF_ADDR);
    assign hit_ie     = (A == IE_ADDR);
    assign wr_commit  = WR & ~wr_q;
    assign pending    = if_q & ie_q[NUM_IRQ-1:0];

    always_comb begin
        rise             = '0;
        rise[3:0]        = int_rise;
        rise[IRQ_JOYPAD] = joy_rise;
        // Edge set beats ACK clear so a request arriving during dispatch is not lost.
        if_next = (((wr_commit && hit_if) ? D_IN[NUM_IRQ-1:0] : if_q) & ~CPU_IRQ_ACK[NUM_IRQ-1:0]) | rise;
        ie_next = (wr_commit && hit_ie) ? D_IN : ie_q;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            if_q         <= '0;
            ie_q         <= 8'h00;
            // A strobe still high when reset lifts must not count as a fresh write.
            wr_q         <= 1'b1;
            CPU_IRQ_TRIG <= 8'h00;
            WAKE         <= 1'b0;
            D_OUT        <= 8'h00;
            D_OE         <= 1'b0;
        end else begin
            if_q         <= if_next;
            ie_q         <= ie_next;
            wr_q         <= WR;
            CPU_IRQ_TRIG <= {{(8-NUM_IRQ){1'b0}}, pending};
            WAKE         <= |pending;
            D_OE         <= RD & (hit_if | hit_ie);
            if (RD && hit_if)      D_OUT <= {{(8-NUM_IRQ){1'b1}}, if_q};
            else if (RD && hit_ie) D_OUT <= ie_q;
            else                   D_OUT <= 8'h00;
        end
    end

endmodule
